// File: rtl/ctrl_seq.sv
// ctrl_seq: registered control decoder and sequencer between instruction fetch
// and the datapath. One instruction is decoded per accept into registered
// control strobes. Loads are held for LOAD_WAIT cycles until memory data is
// ready. Carry ops can split the result and carry write-backs over two cycles
// so that a single register-file write port is sufficient. Stall holds the PC.
module ctrl_seq #(
  parameter int IW          = 9,
  parameter int OPW         = 4,
  parameter int RAW         = 4,
  parameter int LOAD_WAIT   = 1,
  parameter int SPLIT_CARRY = 1,
  parameter int CARRY_A     = 4,
  parameter int CARRY_B     = 0
) (
  input  logic           Clk,
  input  logic           Reset_n,
  input  logic           InstrValid,
  input  logic [IW-1:0]  Instruction,
  output logic           Stall,
  output logic           OpValid,
  output logic           InstructionType,
  output logic           LoadInstr,
  output logic           RegwriteEn,
  output logic           MemWriteEn,
  output logic [1:0]     addrFlag,
  output logic           carryOutRegEn,
  output logic [RAW-1:0] carryOutRegAddr
);

  // The counter only has to hold LOAD_WAIT-1.
  localparam int CW = (LOAD_WAIT > 1) ? $clog2(LOAD_WAIT) : 1;

  localparam logic [OPW-1:0] OP_LOAD    = OPW'(4'b1100);
  localparam logic [OPW-1:0] OP_STORE   = OPW'(4'b1011);
  localparam logic [OPW-1:0] OP_NOWR_A  = OPW'(4'b1010);
  localparam logic [OPW-1:0] OP_NOWR_B  = OPW'(4'b0010);
  localparam logic [OPW-1:0] OP_CARRY_A = OPW'(4'b0000);
  localparam logic [OPW-1:0] OP_CARRY_B = OPW'(4'b0110);
  localparam logic [OPW-1:0] OP_AF3     = OPW'(4'b0001);

  localparam logic [RAW-1:0] CADDR_A = RAW'(CARRY_A);
  localparam logic [RAW-1:0] CADDR_B = RAW'(CARRY_B);

  localparam logic LW_ONE   = (LOAD_WAIT == 1)   ? 1'b1 : 1'b0;
  localparam logic SPLIT_ON = (SPLIT_CARRY != 0) ? 1'b1 : 1'b0;

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_LOAD  = 2'd1,
    S_CARRY = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Instruction decode
  logic           type_s;
  logic [OPW-1:0] opcode_s;
  logic           dec_load_s;
  logic           dec_store_s;
  logic           dec_nowr_s;
  logic           dec_carry_s;
  logic [1:0]     dec_af_s;
  logic [RAW-1:0] dec_caddr_s;
  logic           dec_regwr_s;
  logic           unused_operand_s;

  // Registered control outputs
  logic           stall_q,     stall_d;
  logic           op_valid_q,  op_valid_d;
  logic           type_q,      type_d;
  logic           load_q,      load_d;
  logic           regwr_q,     regwr_d;
  logic           memwr_q,     memwr_d;
  logic [1:0]     af_q,        af_d;
  logic           carry_en_q,  carry_en_d;
  logic [RAW-1:0] caddr_q,     caddr_d;

  logic accept_s;

  assign type_s           = Instruction[IW-1];
  assign opcode_s         = Instruction[IW-2 -: OPW];
  assign unused_operand_s = ^Instruction[IW-OPW-2:0];

  // An instruction is only taken while the sequencer is idle in S_RUN.
  assign accept_s = InstrValid && (state_q == S_RUN);

  // Classify the incoming instruction; type-1 ops are always plain writes.
  always_comb begin
    dec_load_s  = 1'b0;
    dec_store_s = 1'b0;
    dec_nowr_s  = 1'b0;
    dec_carry_s = 1'b0;
    dec_af_s    = 2'b00;
    dec_caddr_s = {RAW{1'b0}};
    if (!type_s) begin
      case (opcode_s)
        OP_LOAD:   dec_load_s  = 1'b1;
        OP_STORE:  dec_store_s = 1'b1;
        OP_NOWR_A,
        OP_NOWR_B: dec_nowr_s  = 1'b1;
        OP_CARRY_A: begin
          dec_carry_s = 1'b1;
          dec_af_s    = 2'b10;
          dec_caddr_s = CADDR_A;
        end
        OP_CARRY_B: begin
          dec_carry_s = 1'b1;
          dec_af_s    = 2'b01;
          dec_caddr_s = CADDR_B;
        end
        OP_AF3:    dec_af_s    = 2'b11;
        default:   dec_af_s    = 2'b00;
      endcase
    end else begin
      dec_af_s = 2'b00;
    end
  end

  // Register write in the first output cycle; a load only writes there when
  // memory answers within one cycle.
  always_comb begin
    if (dec_load_s) begin
      dec_regwr_s = LW_ONE;
    end else if (dec_store_s || dec_nowr_s) begin
      dec_regwr_s = 1'b0;
    end else begin
      dec_regwr_s = 1'b1;
    end
  end

  // State and wait-counter register.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= S_RUN;
      cnt_q   <= {CW{1'b0}};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: multi-cycle ops leave S_RUN, everything returns to it.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_RUN: begin
        if (accept_s && dec_load_s && (LOAD_WAIT > 1)) begin
          state_d = S_LOAD;
          cnt_d   = CW'(LOAD_WAIT - 1);
        end else if (accept_s && dec_carry_s && SPLIT_ON) begin
          state_d = S_CARRY;
          cnt_d   = {CW{1'b0}};
        end else begin
          state_d = S_RUN;
          cnt_d   = {CW{1'b0}};
        end
      end
      S_LOAD: begin
        if (cnt_q == CW'(1)) begin
          state_d = S_RUN;
          cnt_d   = {CW{1'b0}};
        end else begin
          state_d = S_LOAD;
          cnt_d   = cnt_q - CW'(1);
        end
      end
      S_CARRY: begin
        state_d = S_RUN;
        cnt_d   = {CW{1'b0}};
      end
      default: begin
        state_d = S_RUN;
        cnt_d   = {CW{1'b0}};
      end
    endcase
  end

  // Output logic: strobes for the cycle following this clock edge.
  always_comb begin
    op_valid_d = 1'b0;
    type_d     = 1'b0;
    load_d     = 1'b0;
    regwr_d    = 1'b0;
    memwr_d    = 1'b0;
    af_d       = 2'b00;
    carry_en_d = 1'b0;
    caddr_d    = {RAW{1'b0}};
    stall_d    = (state_d != S_RUN);
    case (state_q)
      S_RUN: begin
        if (accept_s) begin
          op_valid_d = 1'b1;
          type_d     = type_s;
          load_d     = dec_load_s;
          regwr_d    = dec_regwr_s;
          memwr_d    = dec_store_s;
          af_d       = dec_af_s;
          carry_en_d = dec_carry_s && !SPLIT_ON;
          caddr_d    = dec_caddr_s;
        end else begin
          op_valid_d = 1'b0;
        end
      end
      S_LOAD: begin
        op_valid_d = 1'b1;
        type_d     = type_q;
        load_d     = 1'b1;
        af_d       = af_q;
        caddr_d    = caddr_q;
        if (cnt_q == CW'(1)) begin
          regwr_d = 1'b1;
        end else begin
          regwr_d = 1'b0;
        end
      end
      S_CARRY: begin
        op_valid_d = 1'b1;
        type_d     = type_q;
        af_d       = af_q;
        caddr_d    = caddr_q;
        carry_en_d = 1'b1;
        regwr_d    = 1'b0;
      end
      default: begin
        op_valid_d = 1'b0;
      end
    endcase
  end

  // Output register: every strobe leaves the block straight from a flop.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      stall_q    <= 1'b0;
      op_valid_q <= 1'b0;
      type_q     <= 1'b0;
      load_q     <= 1'b0;
      regwr_q    <= 1'b0;
      memwr_q    <= 1'b0;
      af_q       <= 2'b00;
      carry_en_q <= 1'b0;
      caddr_q    <= {RAW{1'b0}};
    end else begin
      stall_q    <= stall_d;
      op_valid_q <= op_valid_d;
      type_q     <= type_d;
      load_q     <= load_d;
      regwr_q    <= regwr_d;
      memwr_q    <= memwr_d;
      af_q       <= af_d;
      carry_en_q <= carry_en_d;
      caddr_q    <= caddr_d;
    end
  end

  assign Stall           = stall_q;
  assign OpValid         = op_valid_q;
  assign InstructionType = type_q;
  assign LoadInstr       = load_q;
  assign RegwriteEn      = regwr_q;
  assign MemWriteEn      = memwr_q;
  assign addrFlag        = af_q;
  assign carryOutRegEn   = carry_en_q;
  assign carryOutRegAddr = caddr_q;

endmodule

// File: tb/tb_ctrl_seq.sv
// tb_ctrl_seq: two instances of ctrl_seq (A: LOAD_WAIT=3, SPLIT_CARRY=1;
// B: LOAD_WAIT=1, SPLIT_CARRY=0) share one input stream. A directed vector
// table, a mid-op reset sequence and a random phase are checked against
// constants and against a cycle-of-op reference model.
module tb_ctrl_seq;

  logic       Clk = 1'b0;
  logic       Reset_n;
  logic       InstrValid;
  logic [8:0] Instruction;

  logic a_stall, a_opv, a_typ, a_ld, a_rw, a_mw, a_cen;
  logic [1:0] a_af;
  logic [3:0] a_ca;
  logic b_stall, b_opv, b_typ, b_ld, b_rw, b_mw, b_cen;
  logic [1:0] b_af;
  logic [3:0] b_ca;

  ctrl_seq #(.IW(9), .OPW(4), .RAW(4), .LOAD_WAIT(3), .SPLIT_CARRY(1),
             .CARRY_A(4), .CARRY_B(0)) dut_a (
    .Clk(Clk), .Reset_n(Reset_n), .InstrValid(InstrValid), .Instruction(Instruction),
    .Stall(a_stall), .OpValid(a_opv), .InstructionType(a_typ), .LoadInstr(a_ld),
    .RegwriteEn(a_rw), .MemWriteEn(a_mw), .addrFlag(a_af),
    .carryOutRegEn(a_cen), .carryOutRegAddr(a_ca));

  ctrl_seq #(.IW(9), .OPW(4), .RAW(4), .LOAD_WAIT(1), .SPLIT_CARRY(0),
             .CARRY_A(4), .CARRY_B(0)) dut_b (
    .Clk(Clk), .Reset_n(Reset_n), .InstrValid(InstrValid), .Instruction(Instruction),
    .Stall(b_stall), .OpValid(b_opv), .InstructionType(b_typ), .LoadInstr(b_ld),
    .RegwriteEn(b_rw), .MemWriteEn(b_mw), .addrFlag(b_af),
    .carryOutRegEn(b_cen), .carryOutRegAddr(b_ca));

  always #5 Clk = ~Clk;

  // Packed view: {Stall, OpValid, Type, Load, Regwrite, MemWrite, addrFlag[1:0], carryEn, carryAddr[3:0]}
  wire [12:0] a_out = {a_stall, a_opv, a_typ, a_ld, a_rw, a_mw, a_af, a_cen, a_ca};
  wire [12:0] b_out = {b_stall, b_opv, b_typ, b_ld, b_rw, b_mw, b_af, b_cen, b_ca};

  int checks   = 0;
  int failures = 0;

  function automatic logic [12:0] mk(input int s, input int o, input int t, input int l,
                                     input int r, input int m, input int f, input int c,
                                     input int a);
    return {s[0], o[0], t[0], l[0], r[0], m[0], f[1:0], c[0], a[3:0]};
  endfunction

  task automatic check(input string name, input logic [12:0] act, input logic [12:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b required %b (S,V,T,L,RW,MW,AF,CE,CA)", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Each op is a fixed-length run of output cycles; the model remembers the
  // op in flight and which of its cycles is currently visible.
  int         lw_p[2] = '{3, 1};
  int         sc_p[2] = '{1, 0};
  logic       m_active[2];
  logic [8:0] m_instr[2];
  int         m_k[2];

  function automatic int op_len(input logic [8:0] ins, input int lw, input int sc);
    logic [3:0] op;
    op = ins[7:4];
    if (ins[8]) return 1;
    if (op == 4'b1100) return lw;
    if ((op == 4'b0000 || op == 4'b0110) && sc == 1) return 2;
    return 1;
  endfunction

  function automatic logic [12:0] model_out(input logic act, input logic [8:0] ins,
                                            input int k, input int lw, input int sc);
    logic [3:0] op;
    int len, s, ld, rw, mw, cen, af, ca;
    if (!act) return 13'd0;
    op  = ins[7:4];
    len = op_len(ins, lw, sc);
    s = (k < len) ? 1 : 0;
    ld = 0; rw = 1; mw = 0; cen = 0; af = 0; ca = 0;
    if (!ins[8]) begin
      case (op)
        4'b1100: begin ld = 1; rw = (k == len) ? 1 : 0; end
        4'b1011: begin mw = 1; rw = 0; end
        4'b1010, 4'b0010: rw = 0;
        4'b0000, 4'b0110: begin
          af = (op == 4'b0000) ? 2 : 1;
          ca = (op == 4'b0000) ? 4 : 0;
          if (sc == 1) begin
            rw  = (k == 1) ? 1 : 0;
            cen = (k == 2) ? 1 : 0;
          end else begin
            rw  = 1;
            cen = 1;
          end
        end
        4'b0001: af = 3;
        default: af = 0;
      endcase
    end
    return mk(s, 1, int'(ins[8]), ld, rw, mw, af, cen, ca);
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_active[d] = 1'b0;
      m_instr[d]  = 9'd0;
      m_k[d]      = 0;
    end
  endtask

  task automatic model_step(input logic v, input logic [8:0] ins);
    for (int d = 0; d < 2; d++) begin
      if (m_active[d] && (m_k[d] < op_len(m_instr[d], lw_p[d], sc_p[d]))) begin
        m_k[d]++;
      end else if (v) begin
        m_active[d] = 1'b1;
        m_instr[d]  = ins;
        m_k[d]      = 1;
      end else begin
        m_active[d] = 1'b0;
      end
    end
  endtask

  task automatic model_check(input string tag);
    check({tag, "_model_a"}, a_out, model_out(m_active[0], m_instr[0], m_k[0], lw_p[0], sc_p[0]));
    check({tag, "_model_b"}, b_out, model_out(m_active[1], m_instr[1], m_k[1], lw_p[1], sc_p[1]));
  endtask

  // One clock cycle: drive at the falling edge, step the model at the rising
  // edge, compare at the next falling edge.
  task automatic cycle(input logic v, input logic [8:0] ins, input string tag);
    InstrValid  = v;
    Instruction = ins;
    @(posedge Clk);
    model_step(v, ins);
    @(negedge Clk);
    model_check(tag);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        v;
    logic [8:0]  ins;
    logic [12:0] ea;
    logic [12:0] eb;
  } vec_t;

  vec_t tbl[15];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]  ops[8];
    logic [31:0] rnd;
    logic [8:0]  ins;
    logic        v;

    ops = '{4'b1100, 4'b1011, 4'b1010, 4'b0010, 4'b0000, 4'b0110, 4'b0001, 4'b0111};

    // load (A stalls twice), type-1 and 0001 ignored by A while stalled
    tbl[0]  = '{1'b1, 9'b0_1100_0001, mk(1,1,0,1,0,0,0,0,0), mk(0,1,0,1,1,0,0,0,0)};
    tbl[1]  = '{1'b1, 9'b1_0000_0000, mk(1,1,0,1,0,0,0,0,0), mk(0,1,1,0,1,0,0,0,0)};
    tbl[2]  = '{1'b1, 9'b0_0001_0011, mk(0,1,0,1,1,0,0,0,0), mk(0,1,0,0,1,0,3,0,0)};
    // carry op 0000: split on A, single cycle on B
    tbl[3]  = '{1'b1, 9'b0_0000_0101, mk(1,1,0,0,1,0,2,0,4), mk(0,1,0,0,1,0,2,1,4)};
    tbl[4]  = '{1'b1, 9'b0_1011_0010, mk(0,1,0,0,0,0,2,1,4), mk(0,1,0,0,0,1,0,0,0)};
    // back-to-back store, type-1, 0001
    tbl[5]  = '{1'b1, 9'b0_1011_0010, mk(0,1,0,0,0,1,0,0,0), mk(0,1,0,0,0,1,0,0,0)};
    tbl[6]  = '{1'b1, 9'b1_0110_1111, mk(0,1,1,0,1,0,0,0,0), mk(0,1,1,0,1,0,0,0,0)};
    tbl[7]  = '{1'b1, 9'b0_0001_0000, mk(0,1,0,0,1,0,3,0,0), mk(0,1,0,0,1,0,3,0,0)};
    // two idle cycles: bubbles
    tbl[8]  = '{1'b0, 9'b0_0000_0000, 13'd0, 13'd0};
    tbl[9]  = '{1'b0, 9'b0_1100_0000, 13'd0, 13'd0};
    // carry op 0110
    tbl[10] = '{1'b1, 9'b0_0110_0001, mk(1,1,0,0,1,0,1,0,0), mk(0,1,0,0,1,0,1,1,0)};
    tbl[11] = '{1'b1, 9'b0_1010_0000, mk(0,1,0,0,0,0,1,1,0), mk(0,1,0,0,0,0,0,0,0)};
    tbl[12] = '{1'b1, 9'b0_0010_0000, mk(0,1,0,0,0,0,0,0,0), mk(0,1,0,0,0,0,0,0,0)};
    tbl[13] = '{1'b1, 9'b0_0111_0000, mk(0,1,0,0,1,0,0,0,0), mk(0,1,0,0,1,0,0,0,0)};
    tbl[14] = '{1'b0, 9'b0_0000_0000, 13'd0, 13'd0};

    // Reset held over two rising edges.
    Reset_n     = 1'b0;
    InstrValid  = 1'b0;
    Instruction = 9'd0;
    model_reset();
    @(posedge Clk);
    @(posedge Clk);
    @(negedge Clk);
    check("reset_a", a_out, 13'd0);
    check("reset_b", b_out, 13'd0);
    Reset_n = 1'b1;
    cycle(1'b0, 9'd0, "idle");

    // Directed table.
    for (int i = 0; i < 15; i++) begin
      InstrValid  = tbl[i].v;
      Instruction = tbl[i].ins;
      @(posedge Clk);
      model_step(tbl[i].v, tbl[i].ins);
      @(negedge Clk);
      check($sformatf("vec%0d_a", i), a_out, tbl[i].ea);
      check($sformatf("vec%0d_b", i), b_out, tbl[i].eb);
      model_check($sformatf("vec%0d", i));
    end

    // Reset in the middle of a load on A.
    cycle(1'b1, 9'b0_1100_0001, "rst_ld");
    check("rst_ld_in_load_a", a_out, mk(1,1,0,1,0,0,0,0,0));
    InstrValid = 1'b0;
    #2;
    Reset_n = 1'b0;
    #1;
    check("async_reset_a", a_out, 13'd0);
    check("async_reset_b", b_out, 13'd0);
    model_reset();
    @(negedge Clk);
    check("reset_held_a", a_out, 13'd0);
    Reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 9'b0_1100_0001, "post_rst");
      check($sformatf("post_rst%0d_a", i), a_out, 13'd0);
    end
    cycle(1'b1, 9'b0_0000_1111, "recover");

    // Random phase against the model.
    for (int n = 0; n < 3000; n++) begin
      rnd = $urandom();
      v   = (rnd[3:0] < 4'd11);
      if (rnd[5:4] == 2'b00) begin
        ins = rnd[16:8];
      end else begin
        ins = {(rnd[9:7] == 3'b000), ops[rnd[12:10]], rnd[20:17]};
      end
      cycle(v, ins, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
